// File: rtl/cpu_wb_pkg.sv
// Shared write-back types and register-file constants for the core's write-back path.
package cpu_wb_pkg;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wb_req_t;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         REG_COUNT = 32;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-2 FIFO of write-back requests; pointers and occupancy count reset asynchronously.
module wb_fifo
    import cpu_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output wb_req_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of 2, so natural pointer overflow wraps modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/regfile_wb_arb.sv
// Register-file write-port arbiter: pipeline write-back vs. buffered long-latency results,
// with pending-destination scoreboard. Optional direct path via REGFILE_WB_ARB_BYPASS_EN.
module regfile_wb_arb
    import cpu_wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_wa,
    input  logic        lu_valid,
    input  logic [4:0]  lu_wa,
    input  logic [31:0] lu_wd,
    output logic        lu_ready,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic [31:0] busy,
    output logic        stall_req,
    output logic        proto_err
);

    localparam int              CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   SMAX = CW'(STARVE_MAX);

    logic                 pipe_live;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 bypass;
    wb_req_t              lu_req;
    wb_req_t              head;
    logic [CW-1:0]        starve_cnt;
    logic [CW-1:0]        starve_next;
    logic [REG_COUNT-1:0] busy_next;

    assign pipe_live = pipe_we && (pipe_wa != REG_ZERO);
    assign lu_req    = '{wa: lu_wa, wd: lu_wd};
    assign lu_ready  = !fifo_full;

`ifdef REGFILE_WB_ARB_BYPASS_EN
    assign bypass = fifo_empty && !stall_req && !pipe_live && lu_valid && (lu_wa != REG_ZERO);
`else
    assign bypass = 1'b0;
`endif

    // r0 results are accepted but never stored; bypassed results skip the FIFO.
    assign push = lu_valid && lu_ready && (lu_wa != REG_ZERO) && !bypass;
    // A live pipe request always takes the port, even under stall_req, so nothing is lost.
    assign pop  = !fifo_empty && !pipe_live;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (lu_req),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        starve_next = starve_cnt;
        if (pop || fifo_empty)
            starve_next = '0;
        else if (starve_cnt != SMAX)
            starve_next = starve_cnt + 1'b1;
    end

    always_comb begin
        busy_next = busy;
        if (pop)
            busy_next[head.wa] = 1'b0;
        else if (bypass)
            busy_next[lu_wa] = 1'b0;
        if (lu_issue && (lu_issue_wa != REG_ZERO))
            busy_next[lu_issue_wa] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3        <= 1'b0;
            wa3        <= '0;
            wd3        <= '0;
            busy       <= '0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            busy       <= busy_next;
            starve_cnt <= starve_next;
            stall_req  <= (starve_next == SMAX);
            if (pipe_live && (stall_req || busy[pipe_wa]))
                proto_err <= 1'b1;
            if (pipe_live) begin
                we3 <= 1'b1;
                wa3 <= pipe_wa;
                wd3 <= pipe_wd;
            end else if (pop) begin
                we3 <= 1'b1;
                wa3 <= head.wa;
                wd3 <= head.wd;
            end else if (bypass) begin
                we3 <= 1'b1;
                wa3 <= lu_wa;
                wd3 <= lu_wd;
            end else begin
                we3 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed self-checking bench for regfile_wb_arb (DEPTH=4, STARVE_MAX=8).
module tb_regfile_wb_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        lu_issue;
    logic [4:0]  lu_issue_wa;
    logic        lu_valid;
    logic [4:0]  lu_wa;
    logic [31:0] lu_wd;
    logic        lu_ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] busy;
    logic        stall_req;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    regfile_wb_arb #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_we     (pipe_we),
        .pipe_wa     (pipe_wa),
        .pipe_wd     (pipe_wd),
        .lu_issue    (lu_issue),
        .lu_issue_wa (lu_issue_wa),
        .lu_valid    (lu_valid),
        .lu_wa       (lu_wa),
        .lu_wd       (lu_wd),
        .lu_ready    (lu_ready),
        .we3         (we3),
        .wa3         (wa3),
        .wd3         (wd3),
        .busy        (busy),
        .stall_req   (stall_req),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
        lu_issue = 0; lu_issue_wa = 0;
        lu_valid = 0; lu_wa = 0; lu_wd = 0;
        tick(); tick();
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_wa3", 32'(wa3), 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_proto", 32'(proto_err), 32'd0);
        chk("rst_ready", 32'(lu_ready), 32'd1);
        reset = 1'b0;

        // Pipe write, then a dropped write to r0.
        pipe_we = 1; pipe_wa = 5; pipe_wd = 32'hDEADBEEF;
        tick();
        chk("pipe_we3", 32'(we3), 32'd1);
        chk("pipe_wa3", 32'(wa3), 32'd5);
        chk("pipe_wd3", wd3, 32'hDEADBEEF);
        pipe_wa = 0; pipe_wd = 32'h11111111;
        tick();
        chk("r0_we3", 32'(we3), 32'd0);
        chk("r0_wa3_hold", 32'(wa3), 32'd5);
        chk("r0_wd3_hold", wd3, 32'hDEADBEEF);
        pipe_we = 0;

        // Long-latency result to r7.
        lu_issue = 1; lu_issue_wa = 7;
        tick();
        chk("issue7_busy", busy, 32'h00000080);
        lu_issue = 0;
        lu_valid = 1; lu_wa = 7; lu_wd = 32'h1234;
        tick();
        lu_valid = 0;
`ifdef REGFILE_WB_ARB_BYPASS_EN
        chk("lu7_byp_we3", 32'(we3), 32'd1);
        chk("lu7_byp_wa3", 32'(wa3), 32'd7);
        chk("lu7_byp_wd3", wd3, 32'h1234);
        chk("lu7_byp_busy", busy, 32'd0);
`else
        chk("lu7_q_we3", 32'(we3), 32'd0);
        chk("lu7_q_busy", busy, 32'h00000080);
        tick();
        chk("lu7_we3", 32'(we3), 32'd1);
        chk("lu7_wa3", 32'(wa3), 32'd7);
        chk("lu7_wd3", wd3, 32'h1234);
        chk("lu7_busy", busy, 32'd0);
`endif
        tick();
        chk("lu7_idle_we3", 32'(we3), 32'd0);

        // Same-cycle set and clear of busy[9]: set wins.
        lu_issue = 1; lu_issue_wa = 9;
        tick();
        lu_issue = 0;
        pipe_we = 1; pipe_wa = 1; pipe_wd = 32'h55;
        lu_valid = 1; lu_wa = 9; lu_wd = 32'hAA;
        tick();
        chk("sc_pipe_wa3", 32'(wa3), 32'd1);
        pipe_we = 0; lu_valid = 0;
        lu_issue = 1; lu_issue_wa = 9;
        tick();
        lu_issue = 0;
        chk("sc_pop_we3", 32'(we3), 32'd1);
        chk("sc_pop_wa3", 32'(wa3), 32'd9);
        chk("sc_pop_wd3", wd3, 32'hAA);
        chk("sc_busy9", busy, 32'h00000200);
        chk("sc_proto", 32'(proto_err), 32'd0);

        // Fill the FIFO under a continuously live pipe, then starve into stall_req.
        pipe_we = 1; pipe_wa = 2; pipe_wd = 32'h22;
        lu_valid = 1;
        lu_wa = 10; lu_wd = 32'hA0; tick();
        lu_wa = 11; lu_wd = 32'hA1; tick();
        lu_wa = 12; lu_wd = 32'hA2; tick();
        chk("fill3_ready", 32'(lu_ready), 32'd1);
        lu_wa = 13; lu_wd = 32'hA3; tick();
        lu_valid = 0;
        chk("fill4_ready", 32'(lu_ready), 32'd0);
        chk("fill4_wa3", 32'(wa3), 32'd2);
        tick(); tick(); tick(); tick();
        chk("starve8_stall", 32'(stall_req), 32'd0);
        tick();
        chk("starve9_stall", 32'(stall_req), 32'd1);
        chk("starve9_proto", 32'(proto_err), 32'd0);
        pipe_we = 0;
        tick();
        chk("drain0_wa3", 32'(wa3), 32'd10);
        chk("drain0_wd3", wd3, 32'hA0);
        chk("drain0_stall", 32'(stall_req), 32'd0);
        chk("drain0_ready", 32'(lu_ready), 32'd1);
        tick();
        chk("drain1_wa3", 32'(wa3), 32'd11);
        tick();
        chk("drain2_wa3", 32'(wa3), 32'd12);
        tick();
        chk("drain3_we3", 32'(we3), 32'd1);
        chk("drain3_wa3", 32'(wa3), 32'd13);
        chk("drain3_wd3", wd3, 32'hA3);
        tick();
        chk("drain_done_we3", 32'(we3), 32'd0);
        chk("drain_proto", 32'(proto_err), 32'd0);

        // WAW: live pipe write to a busy register.
        lu_issue = 1; lu_issue_wa = 3;
        tick();
        lu_issue = 0;
        chk("waw_busy_set", busy, 32'h00000208);
        pipe_we = 1; pipe_wa = 3; pipe_wd = 32'h33;
        tick();
        pipe_we = 0;
        chk("waw_we3", 32'(we3), 32'd1);
        chk("waw_wa3", 32'(wa3), 32'd3);
        chk("waw_wd3", wd3, 32'h33);
        chk("waw_proto", 32'(proto_err), 32'd1);
        chk("waw_busy", busy, 32'h00000208);
        tick(); tick();
        chk("waw_sticky", 32'(proto_err), 32'd1);

        // Reset mid-drain with three entries queued.
        pipe_we = 1; pipe_wa = 2; pipe_wd = 32'h44;
        lu_valid = 1; lu_issue = 1;
        lu_wa = 20; lu_wd = 32'hB0; lu_issue_wa = 20; tick();
        lu_wa = 21; lu_wd = 32'hB1; lu_issue_wa = 21; tick();
        lu_wa = 22; lu_wd = 32'hB2; lu_issue_wa = 22; tick();
        pipe_we = 0; lu_valid = 0; lu_issue = 0;
        chk("pre_rst_busy", busy, 32'h00700208);
        chk("pre_rst_we3", 32'(we3), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_we3", 32'(we3), 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_proto", 32'(proto_err), 32'd0);
        chk("mid_rst_wa3", 32'(wa3), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_we3_a", 32'(we3), 32'd0);
        chk("post_rst_ready", 32'(lu_ready), 32'd1);
        tick();
        chk("post_rst_we3_b", 32'(we3), 32'd0);
        tick();
        chk("post_rst_we3_c", 32'(we3), 32'd0);
        chk("post_rst_busy", busy, 32'd0);
        chk("post_rst_stall", 32'(stall_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
